// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM dead-time generator.
package pwm_pkg;

    localparam int DT_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DT_H  = 3'd1,
        ON_H  = 3'd2,
        DT_L  = 3'd3,
        ON_L  = 3'd4,
        FAULT = 3'd5
    } state_t;

endpackage

// File: rtl/pwm_dt_cnt.sv
// Loadable dead-time down-counter; flags the cycle on which the count reaches zero.
module pwm_dt_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The decrement on this edge lands on zero, so the dead interval ends here.
    assign last = (cnt == W'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with dead-time insertion and latched break.
//
// state | meaning
// IDLE  | outputs off, waiting for EN
// DT_H  | dead interval before high side turns on
// ON_H  | high side driven
// DT_L  | dead interval before low side turns on
// ON_L  | low side driven
// FAULT | break latched, outputs off until BRK_CLR
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN,
    input  logic                PWM_IN,
    input  logic [DT_WIDTH-1:0] DTG,
    input  logic                BRK,
    input  logic                BRK_CLR,
    output logic                OUT_H,
    output logic                OUT_L,
    output logic                BRK_FLAG
);

    state_t state, next_state;
    logic   cnt_load, cnt_dec, cnt_last;
    logic   dtg_zero;

    assign dtg_zero = (DTG == '0);

    pwm_dt_cnt #(.W(DT_WIDTH)) u_dt_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (DTG),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        if (BRK) begin
            next_state = FAULT;
        end else if (state == FAULT) begin
            if (BRK_CLR) next_state = IDLE;
        end else if (!EN) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (dtg_zero) begin
                        next_state = PWM_IN ? ON_H : ON_L;
                    end else begin
                        next_state = PWM_IN ? DT_H : DT_L;
                        cnt_load   = 1'b1;
                    end
                end
                DT_H: begin
                    // A pulse shorter than the dead time falls back to the low side.
                    if (!PWM_IN)       next_state = ON_L;
                    else if (cnt_last) next_state = ON_H;
                    else               cnt_dec    = 1'b1;
                end
                ON_H: begin
                    if (!PWM_IN) begin
                        if (dtg_zero) begin
                            next_state = ON_L;
                        end else begin
                            next_state = DT_L;
                            cnt_load   = 1'b1;
                        end
                    end
                end
                DT_L: begin
                    if (PWM_IN)        next_state = ON_H;
                    else if (cnt_last) next_state = ON_L;
                    else               cnt_dec    = 1'b1;
                end
                ON_L: begin
                    if (PWM_IN) begin
                        if (dtg_zero) begin
                            next_state = ON_H;
                        end else begin
                            next_state = DT_H;
                            cnt_load   = 1'b1;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs decode the state being entered so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OUT_H    <= 1'b0;
            OUT_L    <= 1'b0;
            BRK_FLAG <= 1'b0;
        end else begin
            OUT_H    <= (next_state == ON_H);
            OUT_L    <= (next_state == ON_L);
            BRK_FLAG <= (next_state == FAULT);
        end
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter: DT_WIDTH, 8, width of dead-time count DTG.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 EN  input  1  output-stage enable; 0 forces both outputs low.
REQ-005 PWM_IN  input  1  raw PWM from the timer stage, synchronous to clk; no synchronizer.
REQ-006 DTG  input  DT_WIDTH  dead time in clk cycles, 0..2^DT_WIDTH-1.
REQ-007 BRK  input  1  active-high fault/break request, sampled on clk.
REQ-008 BRK_CLR  input  1  active-high fault clear, sampled on clk.
REQ-009 OUT_H  output  1  high-side gate drive, registered.
REQ-010 OUT_L  output  1  low-side gate drive, registered.
REQ-011 BRK_FLAG  output  1  sticky fault indication, registered.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE, DT_H, ON_H, DT_L, ON_L and FAULT; outputs SHALL be registered decodes of state: ON_H -> H=1,L=0; ON_L -> H=0,L=1; all other states -> H=0,L=0.
REQ-013 OUT_H and OUT_L SHALL never both be 1 in any cycle, including reset release and mid-count DTG changes.
REQ-014 In ON_L with PWM_IN=1: if DTG=0, next state ON_H; otherwise next state DT_H, loading the counter with DTG.
REQ-015 In ON_H with PWM_IN=0: if DTG=0, next state ON_L; otherwise next state DT_L, loading the counter with DTG.
REQ-016 In DT_H/DT_L the counter SHALL decrement once per cycle; the state SHALL be held for exactly DTG cycles, then move to ON_H/ON_L respectively.
REQ-017 Latency: PWM_IN edge sampled at edge k -> target output asserts after edge k+DTG; opposite output deasserts after edge k.
REQ-018 Short pulse: in DT_H with PWM_IN=0, next state SHALL be ON_L (abort); in DT_L with PWM_IN=1, next state SHALL be ON_H.
REQ-019 DTG SHALL be sampled only when the counter is loaded; changes during a count SHALL NOT affect the current dead interval.
REQ-020 IDLE with EN=1 SHALL go to DT_H if PWM_IN=1 else DT_L, loading DTG (full dead time on enable; DTG=0 goes straight to ON_H/ON_L).
REQ-021 EN=0 in any non-FAULT state SHALL give next state IDLE.
REQ-022 BRK=1 in any state SHALL give next state FAULT and set BRK_FLAG in the same edge; BRK has priority over EN, PWM_IN and BRK_CLR.
REQ-023 FAULT SHALL be left only when BRK_CLR=1 and BRK=0, going to IDLE and clearing BRK_FLAG in the same edge.

Reset
REQ-024 While rst_n=0: state IDLE, counter 0, OUT_H=0, OUT_L=0, BRK_FLAG=0, applied asynchronously.
REQ-025 After rst_n deasserts, the first transition SHALL follow REQ-020/REQ-021 normally; no output pulse before the full dead time.
REQ-026 Reset asserted mid-dead-time or in FAULT SHALL drive all outputs to 0 immediately and discard the count and fault.

Structure
REQ-027 The state encoding enum and the default DT_WIDTH constant SHALL live in the shared package pwm_pkg.
REQ-028 The loadable down-counter with zero detect SHALL be the sub-module pwm_dt_cnt; FSM and output registers stay in pwm_deadtime.

Verification
REQ-029 DTG=4, EN=1, PWM_IN 0->1 at edge k -> OUT_L=0 after k, OUT_H=1 after k+4, both low for exactly 4 cycles.
REQ-030 DTG=0, PWM_IN toggled every cycle -> OUT_H=PWM_IN, OUT_L=~PWM_IN delayed 1 cycle, never both 1.
REQ-031 DTG=6, PWM_IN high for 3 cycles starting in ON_L -> OUT_H never asserts, OUT_L returns high 1 cycle after PWM_IN falls.
REQ-032 BRK pulsed 1 cycle during ON_H -> both outputs 0 next cycle, BRK_FLAG=1 held; BRK_CLR with BRK=1 -> stays FAULT; BRK_CLR with BRK=0 -> IDLE, then DT_x for DTG cycles.
REQ-033 DTG changed 10->2 mid dead interval -> current interval still 10 cycles, next interval 2 cycles.
REQ-034 rst_n asserted during DT_H -> outputs 0 asynchronously; after release with EN=1, PWM_IN=1, DTG=3 -> OUT_H=1 after 3 dead cycles.
